// File: rtl/btb_update_unit.sv
// Branch resolution and BTB update for the EX stage: same-cycle mispredict
// redirect, a small FIFO of pending BTB writes drained one per cycle, and
// saturating performance counters.
module btb_update_unit #(
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned QDEPTH      = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ex_valid_i,
  input  logic                        ex_is_br_i,
  input  logic [31:0]                 ex_pc_i,
  input  logic [31:0]                 ex_target_i,
  input  logic                        ex_taken_i,
  input  logic                        ex_pred_taken_i,
  input  logic [31:0]                 ex_pred_target_i,
  input  logic                        ex_btb_hit_i,
  input  logic                        ex_btb_bias_i,
  input  logic                        btb_wr_hold_i,
  output logic                        redirect_o,
  output logic [31:0]                 redirect_pc_o,
  output logic                        btb_wren_o,
  output logic [INDEX_WIDTH-1:0]      btb_wr_index_o,
  output logic [32-INDEX_WIDTH-3:0]   btb_wr_tag_o,
  output logic [31:0]                 btb_wr_target_o,
  output logic                        btb_br_taken_o,
  output logic [15:0]                 br_cnt_o,
  output logic [15:0]                 mispred_cnt_o,
  output logic [15:0]                 drop_cnt_o
);

  localparam int unsigned TagW = 32 - INDEX_WIDTH - 2;
  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] index;
    logic [TagW-1:0]        tag;
    logic [31:0]            target;
    logic                   bias;
  } entry_t;

  entry_t            mem_q [QDEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [15:0]       br_cnt_q, mispred_cnt_q, drop_cnt_q;

  logic   taken, tgt_diff, mispredict, push, pop, do_push, drop, empty, full;
  entry_t new_entry;
  entry_t head;

  // Resolution, redirect and FIFO handshake decode.
  always_comb begin
    taken      = ex_is_br_i ? ex_taken_i : 1'b1;
    tgt_diff   = (ex_target_i != ex_pred_target_i);
    mispredict = ex_valid_i & ((taken != ex_pred_taken_i) | (taken & ex_pred_taken_i & tgt_diff));
    redirect_o = mispredict & ~rst_i;
    redirect_pc_o = '0;
    if (redirect_o) redirect_pc_o = taken ? ex_target_i : ex_pc_i + 32'd4;

    empty   = (count_q == '0);
    full    = (count_q == CntW'(QDEPTH));
    push    = ex_valid_i & taken & (~ex_btb_hit_i | tgt_diff) & ~rst_i;
    pop     = ~empty & ~btb_wr_hold_i & ~rst_i;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    do_push = push & (~full | pop);
    drop    = push & full & ~pop;

    new_entry.index  = ex_pc_i[INDEX_WIDTH+1:2];
    new_entry.tag    = ex_pc_i[31:INDEX_WIDTH+2];
    new_entry.target = ex_target_i;
    // Retargets keep the stored bias; fresh allocations start biased taken.
    new_entry.bias   = ex_btb_hit_i ? ex_btb_bias_i : 1'b1;

    head            = mem_q[rd_ptr_q];
    btb_wren_o      = pop;
    btb_wr_index_o  = head.index;
    btb_wr_tag_o    = head.tag;
    btb_wr_target_o = head.target;
    btb_br_taken_o  = head.bias;
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and counter state; reset discards pending entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (ex_valid_i && br_cnt_q != 16'hFFFF)      br_cnt_q      <= br_cnt_q + 16'd1;
      if (mispredict && mispred_cnt_q != 16'hFFFF) mispred_cnt_q <= mispred_cnt_q + 16'd1;
      if (drop && drop_cnt_q != 16'hFFFF)          drop_cnt_q    <= drop_cnt_q + 16'd1;
    end
  end

  // Entry storage is not reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign br_cnt_o      = br_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule
